ham_15_11_decoder_pipe: RTL

- Downstream consumer of the Hamming (15,11) encoder. Receives 15-bit codewords over a valid/ready stream, computes the 4-bit syndrome and corrects any single-bit error.
- Emits the recovered 11-bit data word with error flags, and keeps a saturating count of corrected words.
- Two-stage pipeline with full backpressure. Sits between the channel/storage model and the data sink.

---
 rtl/ham_15_11_pkg.sv | 50 +++++
 rtl/ham_15_11_syndrome.sv | 11 +
 rtl/ham_15_11_decoder_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/ham_15_11_pkg.sv
// Shared Hamming (15,11) definitions: code geometry, data-bit placement,
// syndrome generation, data extraction and single-bit correction.
package ham_15_11_pkg;

  localparam int unsigned N = 15;
  localparam int unsigned K = 11;
  localparam int unsigned R = 4;

  // Codeword bit index holding data bit d[i]; parity bits sit at
  // indices 0, 1, 3, 7 (Hamming positions 1, 2, 4, 8).
  localparam int unsigned DPOS [K] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  // Syndrome bit i is the XOR of every codeword bit whose position (index+1)
  // has bit i set; the resulting value is the erroneous position.
  function automatic logic [R-1:0] calc_syndrome(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if ((((j + 1) >> i) & 32'd1) != 32'd0) begin
          s[i] = s[i] ^ c[j];
        end
      end
    end
    return s;
  endfunction

  function automatic logic [K-1:0] extract_data(input logic [N-1:0] c);
    logic [K-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < K; i++) begin
      d[i] = c[DPOS[i]];
    end
    return d;
  endfunction

  // Flip the bit at position syn (index syn-1); syn == 0 leaves c untouched.
  function automatic logic [N-1:0] correct_code(input logic [N-1:0] c,
                                                input logic [R-1:0] syn);
    logic [N-1:0] r;
    r = c;
    for (int unsigned j = 0; j < N; j++) begin
      if (syn == R'(j + 1)) begin
        r[j] = ~c[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ham_15_11_syndrome.sv
// Combinational 15-to-4 Hamming syndrome generator.
module ham_15_11_syndrome
  import ham_15_11_pkg::*;
(
  input  logic [14:0] code_i,
  output logic [3:0]  syn_o
);

  assign syn_o = calc_syndrome(code_i);

endmodule

// File: rtl/ham_15_11_decoder_pipe.sv
// Two-stage Hamming (15,11) decoder with valid/ready backpressure and a
// saturating count of delivered corrected words.
module ham_15_11_decoder_pipe
  import ham_15_11_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_err,
  output logic [3:0]       out_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt
);

  logic             s1_v_q;
  logic [14:0]      s1_code_q;
  logic [3:0]       s1_syn_q;
  logic [3:0]       syn_d;
  logic             out_valid_q;
  logic [10:0]      out_data_q;
  logic             out_err_q;
  logic [3:0]       out_pos_q;
  logic [10:0]      out_data_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_hs;
  logic             out_hs;

  ham_15_11_syndrome u_syn (
    .code_i (in_code),
    .syn_o  (syn_d)
  );

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_v_q && s2_adv;
  assign in_ready = !rst_n || !s1_v_q || s2_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Stage 1: capture the accepted codeword and its syndrome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_code_q <= '0;
      s1_syn_q  <= '0;
    end else if (in_hs) begin
      s1_v_q    <= 1'b1;
      s1_code_q <= in_code;
      s1_syn_q  <= syn_d;
    end else if (s1_adv) begin
      s1_v_q    <= 1'b0;
    end
  end

  // Correct the stage-1 word and pull out its data bits.
  always_comb begin
    out_data_d = extract_data(correct_code(s1_code_q, s1_syn_q));
  end

  // Stage 2: register corrected data and flags; hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_pos_q   <= '0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_err_q   <= (s1_syn_q != 4'd0);
      out_pos_q   <= s1_syn_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating corrected-word counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_hs && out_err_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_pos   = out_pos_q;
  assign corr_cnt  = cnt_q;

endmodule
